// File: rtl/video_pattern_gen.sv
// Raster timing generator with four YCbCr 4:4:4 test patterns.
// Every output is registered, so each output lags its raster position by one clock.
module video_pattern_gen #(
    parameter int H_ACTIVE   = 64,
    parameter int H_FP       = 4,
    parameter int H_SYNC     = 8,
    parameter int H_BP       = 7,
    parameter int V_ACTIVE   = 48,
    parameter int V_FP       = 2,
    parameter int V_SYNC     = 3,
    parameter int V_BP       = 3,
    parameter int LOG2_BAR_W = 3,
    parameter int LOG2_CELL  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  pattern_sel,
    input  logic [23:0] solid_color,
    output logic [23:0] pixel_out,
    output logic        de_out,
    output logic        h_sync_out,
    output logic        v_sync_out,
    output logic        frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    // One extra bit so that bounds equal to the total still fit.
    localparam logic [HW:0]   H_ACT_END  = (HW+1)'(H_ACTIVE);
    localparam logic [HW:0]   H_SYNC_BEG = (HW+1)'(H_ACTIVE + H_FP);
    localparam logic [HW:0]   H_SYNC_END = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW:0]   V_ACT_END  = (VW+1)'(V_ACTIVE);
    localparam logic [VW:0]   V_SYNC_BEG = (VW+1)'(V_ACTIVE + V_FP);
    localparam logic [VW:0]   V_SYNC_END = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);

    if (H_ACTIVE < 1 || H_SYNC < 1 || V_SYNC < 1 || H_FP < 0 || H_BP < 0 ||
        V_FP < 0 || V_BP < 0 || V_ACTIVE < 1) begin : g_param_check
        $error("video_pattern_gen: illegal raster timing parameters");
    end

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [1:0]    pattern_q;

    logic          first;
    logic          active;
    logic          hs;
    logic          vs;
    logic [1:0]    cur_pat;
    logic [23:0]   pix;

    always_comb begin
        first   = (h_cnt == '0) && (v_cnt == '0);
        active  = ({1'b0, h_cnt} < H_ACT_END) && ({1'b0, v_cnt} < V_ACT_END);
        hs      = ({1'b0, h_cnt} >= H_SYNC_BEG) && ({1'b0, h_cnt} < H_SYNC_END);
        vs      = ({1'b0, v_cnt} >= V_SYNC_BEG) && ({1'b0, v_cnt} < V_SYNC_END);
        // The frame's first pixel already uses the pattern being latched now.
        cur_pat = first ? pattern_sel : pattern_q;
        pix     = '0;
        case (cur_pat)
            2'd0: pix = {h_cnt[5:0], 2'b00, 16'h8080};
            2'd1: pix = {h_cnt[LOG2_BAR_W+2:LOG2_BAR_W], 5'b00000, 16'h8080};
            2'd2: pix = {(h_cnt[LOG2_CELL] ^ v_cnt[LOG2_CELL]) ? 8'hEB : 8'h10, 16'h8080};
            default: pix = solid_color;
        endcase
        if (!active) begin
            pix = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            pattern_q   <= '0;
            pixel_out   <= '0;
            de_out      <= 1'b0;
            h_sync_out  <= 1'b0;
            v_sync_out  <= 1'b0;
            frame_start <= 1'b0;
        end else if (!en) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            pixel_out   <= '0;
            de_out      <= 1'b0;
            h_sync_out  <= 1'b0;
            v_sync_out  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
            if (first) begin
                pattern_q <= pattern_sel;
            end
            pixel_out   <= pix;
            de_out      <= active;
            h_sync_out  <= hs;
            v_sync_out  <= vs;
            frame_start <= active && first;
        end
    end
endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen: full-frame timing scans, a pixel vector
// table per pattern, and hand-written reset / enable / pattern-latch sequences.
module tb_video_pattern_gen;
    localparam int HT    = 83;
    localparam int VT    = 56;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  pattern_sel;
    logic [23:0] solid_color;
    logic [23:0] pixel_out;
    logic        de_out;
    logic        h_sync_out;
    logic        v_sync_out;
    logic        frame_start;

    int checks = 0;
    int errors = 0;
    int pos    = 0;

    typedef struct {
        logic [1:0]  pat;
        int          x;
        int          y;
        logic [23:0] solid;
        logic [23:0] exp_pix;
        logic        exp_de;
    } vec_t;

    vec_t vecs [0:19];

    video_pattern_gen dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .pattern_sel (pattern_sel),
        .solid_color (solid_color),
        .pixel_out   (pixel_out),
        .de_out      (de_out),
        .h_sync_out  (h_sync_out),
        .v_sync_out  (v_sync_out),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        pos = (pos + 1) % FRAME;
    endtask

    task automatic advance_to(input int idx);
        while (pos != idx) tick();
    endtask

    task automatic advance_frame();
        tick();
        while (pos != 0) tick();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [27:0] all_outs();
        return {pixel_out, de_out, h_sync_out, v_sync_out, frame_start};
    endfunction

    // Walks one whole frame starting at pos 0 and checks timing and pixels.
    task automatic scan_frame(input logic [1:0] pat, input logic [23:0] solid);
        int de_cnt = 0, hs_cnt = 0, vs_cnt = 0, fs_cnt = 0;
        int first_hs = -1, second_hs = -1, first_vs = -1;
        int tim_bad = 0, pix_bad = 0;
        for (int i = 0; i < FRAME; i++) begin
            int x = i % HT;
            int y = i / HT;
            logic e_de = (x < 64) && (y < 48);
            logic e_hs = (x >= 68) && (x < 76);
            logic e_vs = (y >= 50) && (y < 53);
            logic [23:0] e_pix = (pat == 2'd3) ? solid : {8'(x * 4), 16'h8080};
            if (!e_de) e_pix = 24'h0;
            if (de_out) de_cnt++;
            if (h_sync_out) begin
                hs_cnt++;
                if (first_hs < 0) first_hs = i;
                else if (second_hs < 0 && i >= 83) second_hs = i;
            end
            if (v_sync_out) begin
                vs_cnt++;
                if (first_vs < 0) first_vs = i;
            end
            if (frame_start) fs_cnt++;
            if (de_out !== e_de || h_sync_out !== e_hs || v_sync_out !== e_vs) tim_bad++;
            if (pixel_out !== e_pix) pix_bad++;
            tick();
        end
        check("de_count", de_cnt, 3072);
        check("hs_count", hs_cnt, 448);
        check("vs_count", vs_cnt, 249);
        check("fs_count", fs_cnt, 1);
        check("hs_first_pos", first_hs, 68);
        check("hs_line_period", second_hs, 151);
        check("vs_first_pos", first_vs, 4150);
        check("timing_errs", tim_bad, 0);
        check("pixel_errs", pix_bad, 0);
        check("frame_period_fs", frame_start, 1'b1);
    endtask

    initial begin
        logic [1:0] cur_pat;
        int bad;

        vecs[0]  = '{2'd0, 0,  0,  24'h0, 24'h008080, 1'b1};
        vecs[1]  = '{2'd0, 1,  0,  24'h0, 24'h048080, 1'b1};
        vecs[2]  = '{2'd0, 63, 0,  24'h0, 24'hFC8080, 1'b1};
        vecs[3]  = '{2'd0, 64, 0,  24'h0, 24'h000000, 1'b0};
        vecs[4]  = '{2'd0, 5,  47, 24'h0, 24'h148080, 1'b1};
        vecs[5]  = '{2'd0, 0,  48, 24'h0, 24'h000000, 1'b0};
        vecs[6]  = '{2'd1, 0,  0,  24'h0, 24'h008080, 1'b1};
        vecs[7]  = '{2'd1, 7,  0,  24'h0, 24'h008080, 1'b1};
        vecs[8]  = '{2'd1, 8,  0,  24'h0, 24'h208080, 1'b1};
        vecs[9]  = '{2'd1, 15, 0,  24'h0, 24'h208080, 1'b1};
        vecs[10] = '{2'd1, 56, 0,  24'h0, 24'hE08080, 1'b1};
        vecs[11] = '{2'd1, 63, 3,  24'h0, 24'hE08080, 1'b1};
        vecs[12] = '{2'd2, 0,  0,  24'h0, 24'h108080, 1'b1};
        vecs[13] = '{2'd2, 8,  0,  24'h0, 24'hEB8080, 1'b1};
        vecs[14] = '{2'd2, 0,  8,  24'h0, 24'hEB8080, 1'b1};
        vecs[15] = '{2'd2, 8,  8,  24'h0, 24'h108080, 1'b1};
        vecs[16] = '{2'd2, 20, 47, 24'h0, 24'hEB8080, 1'b1};
        vecs[17] = '{2'd3, 0,  0,  24'h51F05A, 24'h51F05A, 1'b1};
        vecs[18] = '{2'd3, 63, 47, 24'h51F05A, 24'h51F05A, 1'b1};
        vecs[19] = '{2'd3, 70, 10, 24'h51F05A, 24'h000000, 1'b0};

        rst = 1'b1; en = 1'b0; pattern_sel = 2'd0; solid_color = 24'h0;
        tick(); tick();
        check("reset_outputs", all_outs(), 0);
        rst = 1'b0;
        tick(); tick(); tick();
        check("idle_outputs", all_outs(), 0);

        en = 1'b1;
        tick();
        pos = 0;
        check("first_fs", {frame_start, de_out, pixel_out}, {2'b11, 24'h008080});

        scan_frame(2'd0, 24'h0);

        cur_pat = 2'd0;
        for (int i = 0; i < 20; i++) begin
            solid_color = vecs[i].solid;
            if (vecs[i].pat != cur_pat) begin
                pattern_sel = vecs[i].pat;
                advance_frame();
                cur_pat = vecs[i].pat;
            end
            advance_to(vecs[i].y * HT + vecs[i].x);
            check($sformatf("vec%0d", i), {de_out, pixel_out}, {vecs[i].exp_de, vecs[i].exp_pix});
        end

        advance_frame();
        scan_frame(2'd3, 24'h51F05A);

        // Pattern change mid-frame only applies from the next frame.
        pattern_sel = 2'd1;
        advance_frame();
        advance_to(8);
        check("bars_x8", pixel_out, 24'h208080);
        pattern_sel = 2'd2;
        advance_to(56);
        check("midframe_still_bars", pixel_out, 24'hE08080);
        advance_frame();
        check("next_frame_checker0", pixel_out, 24'h108080);
        advance_to(8);
        check("next_frame_checker8", pixel_out, 24'hEB8080);

        // Asynchronous reset in active video and again in sync.
        advance_to(5 * HT + 10);
        check("pre_rst_pixel", {de_out, pixel_out}, {1'b1, 24'hEB8080});
        rst = 1'b1;
        #1;
        check("async_rst_active", all_outs(), 0);
        tick();
        rst = 1'b0;
        tick();
        pos = 0;
        check("restart_fs", {frame_start, de_out, pixel_out}, {2'b11, 24'h108080});
        advance_to(51 * HT + 70);
        check("pre_rst_sync", {h_sync_out, v_sync_out}, 2'b11);
        rst = 1'b1;
        #1;
        check("async_rst_sync", all_outs(), 0);
        tick();
        rst = 1'b0;
        tick();
        pos = 0;
        check("restart2_fs", {frame_start, de_out}, 2'b11);

        // Enable dropped mid-frame for ten cycles.
        advance_to(10 * HT + 20);
        en = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (all_outs() !== 28'h0) bad++;
        end
        check("en_low_outputs", bad, 0);
        en = 1'b1;
        tick();
        pos = 0;
        check("reenable_fs", {frame_start, de_out, pixel_out}, {2'b11, 24'h108080});
        advance_to(47 * HT + 63);
        check("reenable_last_px", {de_out, pixel_out}, {1'b1, 24'h108080});
        advance_to(48 * HT);
        check("reenable_blank", {de_out, pixel_out}, 25'h0);

        // en falling on the cycle that would produce frame_start.
        advance_to(FRAME - 1);
        en = 1'b0;
        tick();
        check("en_fall_fs_suppressed", {frame_start, de_out}, 2'b00);
        en = 1'b1;
        tick();
        pos = 0;
        check("en_rise_fs", frame_start, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
